// File: rtl/ship_sprite_renderer.sv
// Ship sprite line renderer: fetches the ROM row the ship covers on the next
// scanline during horizontal blanking, buffers it, then serialises it into a
// 1-bit pixel mask as the beam passes the ship's left column.
// Optional feature macro: SHIP_MIRROR_EN adds a `flip` input that mirrors the
// fetched row horizontally (sampled at the fetch trigger).
module ship_sprite_renderer #(
  parameter int unsigned SPRITE_W  = 16,
  parameter int unsigned SPRITE_H  = 8,
  parameter int unsigned ADDR_BASE = 0,
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned V_TOTAL   = 525,
  parameter int unsigned FETCH_X   = 640
) (
  input  logic                Clk,
  input  logic                Reset,
`ifdef SHIP_MIRROR_EN
  input  logic                flip,
`endif
  input  logic                pix_en,
  input  logic [9:0]          DrawX,
  input  logic [9:0]          DrawY,
  input  logic [9:0]          ShipX,
  input  logic [9:0]          ShipY,
  output logic [7:0]          rom_addr,
  input  logic [SPRITE_W-1:0] rom_data,
  output logic                pixel_on
);

  localparam int unsigned CNT_W = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADDR    = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [10:0]         r_row;
  logic [9:0]          r_lat_x;
  logic                r_hit;
  logic                r_flip;
  logic [SPRITE_W-1:0] r_line_buf;
  logic                r_line_valid;
  logic [SPRITE_W-1:0] r_shreg;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_trigger;
  logic [9:0]          w_ny;
  logic [10:0]         w_row;
  logic                w_row_hit;
  logic                w_flip;
  logic [SPRITE_W-1:0] w_rev;
  logic [SPRITE_W-1:0] w_fetch;

`ifdef SHIP_MIRROR_EN
  assign w_flip = flip;
`else
  assign w_flip = 1'b0;
`endif

  // Fetch trigger and next-line row arithmetic (11-bit, sign bit = row above the ship)
  assign w_trigger = pix_en && (DrawX == 10'(FETCH_X));
  assign w_ny      = (DrawY == 10'(V_TOTAL - 1)) ? 10'd0 : DrawY + 10'd1;
  assign w_row     = {1'b0, w_ny} - {1'b0, ShipY};
  assign w_row_hit = !r_row[10] && (r_row < 11'(SPRITE_H));

  // Bit-reversed copy of the ROM word for mirrored drawing
  always_comb begin
    w_rev = '0;
    for (int i = 0; i < int'(SPRITE_W); i++) begin
      w_rev[i] = rom_data[int'(SPRITE_W) - 1 - i];
    end
  end

  assign w_fetch = r_flip ? w_rev : rom_data;

  // Fetch FSM state register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Fetch FSM next-state: a trigger is only honoured in IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_trigger) w_state_nxt = ADDR;
      ADDR:    w_state_nxt = CAPTURE;
      CAPTURE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Fetch datapath: latch position at trigger, address the ROM, capture the row
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_row        <= '0;
      r_lat_x      <= '0;
      r_hit        <= 1'b0;
      r_flip       <= 1'b0;
      rom_addr     <= '0;
      r_line_buf   <= '0;
      r_line_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_trigger) begin
            r_row        <= w_row;
            r_lat_x      <= ShipX;
            r_flip       <= w_flip;
            r_line_valid <= 1'b0;
          end
        end
        ADDR: begin
          r_hit <= w_row_hit;
          if (w_row_hit) rom_addr <= 8'(ADDR_BASE + 32'(r_row));
        end
        CAPTURE: begin
          if (r_hit) begin
            r_line_buf   <= w_fetch;
            r_line_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Draw path: load at the latched column, shift one bit per pixel strobe,
  // blank outside the active area and drop any bits left at end of line
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_shreg  <= '0;
      r_cnt    <= '0;
      pixel_on <= 1'b0;
    end else if (pix_en) begin
      if (DrawX >= 10'(H_ACTIVE)) begin
        pixel_on <= 1'b0;
        r_cnt    <= '0;
      end else if (r_line_valid && (DrawX == r_lat_x) && (r_cnt == '0)) begin
        r_shreg  <= r_line_buf;
        pixel_on <= r_line_buf[SPRITE_W-1];
        r_cnt    <= CNT_W'(SPRITE_W - 1);
      end else if (r_cnt != '0) begin
        r_shreg  <= {r_shreg[SPRITE_W-2:0], 1'b0};
        pixel_on <= r_shreg[SPRITE_W-2];
        r_cnt    <= r_cnt - CNT_W'(1);
      end else begin
        pixel_on <= 1'b0;
      end
    end
  end

endmodule
